id_token_scanner: RTL

- Streaming character-class FSM that recognises identifier tokens in a byte stream: an alphanumeric run containing at least one letter.
- Generalises the single-bit identifier-digit detector:
  - adds a valid qualifier;
  - adds an optional underscore-as-letter mode;
  - adds a minimum trailing-digit threshold;
  - reports token length at the end of each token.
- Sits between the character source and downstream lexer/statistics logic; one character per clock maximum.

---
 rtl/id_token_scanner.sv | 107 ++++++++++
 1 files changed

// File: rtl/id_token_scanner.sv
// Streaming identifier-token scanner: classifies bytes, tracks alnum runs,
// flags identifier digits and reports the length of each terminated identifier.
//
// state      | meaning
// -----------+------------------------------------------
// S_IDLE     | outside any alphanumeric run
// S_NUMRUN   | run so far contains only digits
// S_ID_ALPHA | identifier run, last char was a letter
// S_ID_DIGIT | identifier run, last char was a digit
module id_token_scanner #(
  parameter bit          ALLOW_UNDERSCORE = 1'b1,
  parameter int unsigned MIN_DIGITS       = 1,
  parameter int unsigned LEN_W            = 6,
  parameter int unsigned DRUN_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [7:0]       char,
  output logic             out_valid,
  output logic             match,
  output logic             token_done,
  output logic [LEN_W-1:0] token_len,
  output logic             len_ovf
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_NUMRUN   = 2'd1,
    S_ID_ALPHA = 2'd2,
    S_ID_DIGIT = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
  localparam logic [DRUN_W-1:0] DRUN_MAX = '1;
  localparam logic [DRUN_W:0]   MIN_D    = (DRUN_W+1)'(MIN_DIGITS);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DRUN_W-1:0] drun_q, drun_d;
  logic              is_digit, is_alpha, in_id, digits_ok;
  logic              match_d, done_d;
  logic [LEN_W-1:0]  len_inc;
  logic [DRUN_W-1:0] drun_inc;

  always_comb begin
    is_digit  = (char >= 8'h30) && (char <= 8'h39);
    is_alpha  = ((char >= 8'h41) && (char <= 8'h5A)) ||
                ((char >= 8'h61) && (char <= 8'h7A)) ||
                (ALLOW_UNDERSCORE && (char == 8'h5F));
    in_id     = (state_q == S_ID_ALPHA) || (state_q == S_ID_DIGIT);
    // Compare one bit wider so a saturated run still satisfies the threshold.
    digits_ok = ({1'b0, drun_q} + 1'b1) >= MIN_D;
    len_inc   = (len_q == LEN_MAX) ? LEN_MAX : len_q + 1'b1;
    drun_inc  = (drun_q == DRUN_MAX) ? DRUN_MAX : drun_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    drun_d  = drun_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    if (char_valid) begin
      if (is_digit) begin
        state_d = (state_q == S_IDLE || state_q == S_NUMRUN) ? S_NUMRUN : S_ID_DIGIT;
        len_d   = (state_q == S_IDLE) ? LEN_W'(1) : len_inc;
        drun_d  = drun_inc;
        match_d = in_id && digits_ok;
      end else if (is_alpha) begin
        state_d = S_ID_ALPHA;
        len_d   = (state_q == S_IDLE) ? LEN_W'(1) : len_inc;
        drun_d  = '0;
      end else begin
        state_d = S_IDLE;
        len_d   = '0;
        drun_d  = '0;
        done_d  = in_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      drun_q     <= '0;
      out_valid  <= 1'b0;
      match      <= 1'b0;
      token_done <= 1'b0;
      token_len  <= '0;
      len_ovf    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      drun_q     <= drun_d;
      out_valid  <= char_valid;
      match      <= match_d;
      token_done <= done_d;
      if (done_d) begin
        token_len <= len_q;
        len_ovf   <= (len_q == LEN_MAX);
      end
    end
  end

endmodule
